// File: rtl/debug_unit_ctrl.sv
// Host-side debug controller: decodes UART command bytes to load instruction memory,
// run or single-step the pipeline, and stream back cycle count, PC, registers and data memory.
module debug_unit_ctrl #(
  parameter int                 NB_DATA     = 32,
  parameter int                 NB_ADDR     = 7,
  parameter int                 NB_REG      = 5,
  parameter int                 N_MEM_WORDS = 32,
  parameter int                 READ_LAT    = 1,
  parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFFFFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [NB_DATA-1:0] inst_data,
  output logic [NB_ADDR-1:0] inst_addr,
  output logic               inst_write,
  output logic               en_read_inst,
  output logic               en_pipeline,
  input  logic               halt_wb,
  output logic               select_reg_dbg,
  output logic [NB_REG-1:0]  addr_reg_debug,
  input  logic [NB_DATA-1:0] data_reg_debug,
  output logic               select_mem_dbg,
  output logic [NB_ADDR-1:0] addr_mem_debug,
  input  logic [NB_DATA-1:0] data_mem_debug,
  input  logic [NB_ADDR-1:0] pc_debug,
  output logic               busy
);
  localparam int             IW       = ((NB_ADDR > NB_REG) ? NB_ADDR : NB_REG) + 1;
  localparam logic [IW-1:0]  REG_LAST = IW'((2**NB_REG) - 1);
  localparam logic [IW-1:0]  MEM_LAST = IW'(N_MEM_WORDS - 1);
  localparam logic [7:0]     RL       = 8'(READ_LAT);
  localparam logic [1:0]     SEC_CNT = 2'd0, SEC_PC = 2'd1, SEC_REG = 2'd2, SEC_MEM = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOAD_WR, S_RUN, S_STEP, S_DADDR, S_DSEND} state_t;

  typedef struct packed {
    logic               halt_flag;
    logic [31:0]        cycle_cnt;
    logic [NB_ADDR-1:0] ptr;
    logic [NB_DATA-9:0] asm_word;   // first three bytes of the word being loaded
    logic [1:0]         byte_cnt;
    logic [1:0]         sec;
    logic [IW-1:0]      idx;
    logic [7:0]         wait_cnt;
    logic [23:0]        shreg;      // bytes still to send after tx_data
    logic [1:0]         bytes_left;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic [NB_DATA-1:0] inst_data;
    logic [NB_ADDR-1:0] inst_addr;
    logic               inst_write;
    logic               en_read_inst;
    logic               en_pipeline;
    logic               sel_reg;
    logic [NB_REG-1:0]  addr_reg;
    logic               sel_mem;
    logic [NB_ADDR-1:0] addr_mem;
    logic               busy;
  } regs_t;

  state_t      state, state_nxt;
  regs_t       r, r_n;
  logic        load_done, load_rx, last_rx, capture, tx_fire, word_sent, sec_end, dump_done;
  logic [1:0]  sec_nx;
  logic [IW-1:0] idx_nx;
  logic [31:0] cap_word;

  // In LOAD_WR the output registers still hold the word just written.
  assign load_done = (r.inst_data == HALT_WORD) || (r.inst_addr == '1);
  assign load_rx   = rx_valid && (state == S_LOAD || (state == S_LOAD_WR && !load_done));
  assign last_rx   = load_rx && (r.byte_cnt == 2'd3);
  assign capture   = (state == S_DADDR) && (r.wait_cnt == RL);
  assign tx_fire   = r.tx_valid && tx_ready;
  assign word_sent = (state == S_DSEND) && tx_fire && (r.bytes_left == 2'd0);
  assign sec_end   = (r.sec == SEC_CNT) || (r.sec == SEC_PC) ||
                     (r.sec == SEC_REG && r.idx == REG_LAST) ||
                     (r.sec == SEC_MEM && r.idx == MEM_LAST);
  assign dump_done = (r.sec == SEC_MEM) && (r.idx == MEM_LAST);
  assign sec_nx    = sec_end ? r.sec + 2'd1 : r.sec;
  assign idx_nx    = sec_end ? '0 : r.idx + IW'(1);

  always_comb begin
    cap_word = r.cycle_cnt;
    case (r.sec)
      SEC_PC:  cap_word = {8'(pc_debug), 24'h0};
      SEC_REG: cap_word = 32'(data_reg_debug);
      SEC_MEM: cap_word = 32'(data_mem_debug);
      default: cap_word = r.cycle_cnt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rx_valid) begin
                   if (rx_data == 8'h01)      state_nxt = S_LOAD;
                   else if (rx_data == 8'h02) state_nxt = S_RUN;
                   else if (rx_data == 8'h03) state_nxt = S_STEP;
                 end
      S_LOAD:    if (last_rx) state_nxt = S_LOAD_WR;
      S_LOAD_WR: state_nxt = load_done ? S_IDLE : S_LOAD;
      S_RUN:     if (halt_wb || r.halt_flag) state_nxt = S_DADDR;
      S_STEP:    state_nxt = S_DADDR;
      S_DADDR:   if (capture) state_nxt = S_DSEND;
      S_DSEND:   if (word_sent) state_nxt = dump_done ? S_IDLE : S_DADDR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    r_n            = r;
    r_n.inst_write = 1'b0;
    r_n.busy       = (state_nxt != S_IDLE);
    r_n.cycle_cnt  = r.cycle_cnt + {31'b0, r.en_pipeline};
    if (load_rx) begin
      r_n.asm_word = {r.asm_word[NB_DATA-17:0], rx_data};
      r_n.byte_cnt = r.byte_cnt + 2'd1;
    end
    if (last_rx) begin
      r_n.inst_write = 1'b1;
      r_n.inst_data  = {r.asm_word, rx_data};
      r_n.inst_addr  = r.ptr;
    end
    case (state)
      S_IDLE: if (rx_valid) begin
        if (rx_data == 8'h01) begin
          r_n.en_read_inst = 1'b0;
          r_n.halt_flag    = 1'b0;
          r_n.cycle_cnt    = '0;
          r_n.ptr          = '0;
          r_n.byte_cnt     = '0;
        end else if (rx_data == 8'h02 || rx_data == 8'h03) begin
          r_n.en_pipeline = !r.halt_flag;
        end
      end
      S_LOAD_WR: begin
        r_n.ptr = r.ptr + NB_ADDR'(1);
        if (load_done) r_n.en_read_inst = 1'b1;
      end
      S_RUN: if (halt_wb) begin
        r_n.halt_flag   = 1'b1;
        r_n.en_pipeline = 1'b0;
      end
      S_STEP: begin
        r_n.en_pipeline = 1'b0;
        if (halt_wb) r_n.halt_flag = 1'b1;
      end
      S_DADDR: if (capture) begin
        r_n.tx_data    = cap_word[31:24];
        r_n.shreg      = cap_word[23:0];
        r_n.tx_valid   = 1'b1;
        r_n.bytes_left = (r.sec == SEC_PC) ? 2'd0 : 2'd3;
      end else begin
        r_n.wait_cnt = r.wait_cnt + 8'd1;
      end
      S_DSEND: if (tx_fire) begin
        if (r.bytes_left != 2'd0) begin
          r_n.tx_data    = r.shreg[23:16];
          r_n.shreg      = {r.shreg[15:0], 8'h00};
          r_n.bytes_left = r.bytes_left - 2'd1;
        end else begin
          // After the last memory word sec wraps to SEC_CNT, dropping both selects.
          r_n.tx_valid = 1'b0;
          r_n.sec      = sec_nx;
          r_n.idx      = idx_nx;
          r_n.wait_cnt = '0;
          r_n.sel_reg  = (sec_nx == SEC_REG);
          r_n.sel_mem  = (sec_nx == SEC_MEM);
          if (sec_nx == SEC_REG) r_n.addr_reg = idx_nx[NB_REG-1:0];
          if (sec_nx == SEC_MEM) r_n.addr_mem = idx_nx[NB_ADDR-1:0];
        end
      end
      default: ;
    endcase
    if ((state == S_RUN || state == S_STEP) && state_nxt == S_DADDR) begin
      r_n.sec      = SEC_CNT;
      r_n.idx      = '0;
      r_n.wait_cnt = '0;
      r_n.sel_reg  = 1'b0;
      r_n.sel_mem  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r              <= '0;
      r.en_read_inst <= 1'b1;
    end else begin
      r <= r_n;
    end
  end

  assign tx_data        = r.tx_data;
  assign tx_valid       = r.tx_valid;
  assign inst_data      = r.inst_data;
  assign inst_addr      = r.inst_addr;
  assign inst_write     = r.inst_write;
  assign en_read_inst   = r.en_read_inst;
  assign en_pipeline    = r.en_pipeline;
  assign select_reg_dbg = r.sel_reg;
  assign addr_reg_debug = r.addr_reg;
  assign select_mem_dbg = r.sel_mem;
  assign addr_mem_debug = r.addr_mem;
  assign busy           = r.busy;
endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed bench for debug_unit_ctrl: load, run, step, dump stream, tx back-pressure and reset abort.
module tb_debug_unit_ctrl;
  logic        clock = 1'b0;
  logic        reset, rx_valid, tx_valid, tx_ready, inst_write, en_read_inst, en_pipeline, halt_wb;
  logic        select_reg_dbg, select_mem_dbg, busy;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] inst_data, data_reg_debug, data_mem_debug;
  logic [6:0]  inst_addr, addr_mem_debug, pc_debug;
  logic [4:0]  addr_reg_debug;

  int checks = 0, errors = 0, en_cnt = 0;
  logic [7:0]  rx_q[$], exp_q[$];
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [4:0]  reg_seq[$];
  logic        prev_sel = 1'b0, stalled = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [7:0]  stall_data = '0;

  always #5 clock = ~clock;

  debug_unit_ctrl dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_data(inst_data), .inst_addr(inst_addr), .inst_write(inst_write),
    .en_read_inst(en_read_inst), .en_pipeline(en_pipeline), .halt_wb(halt_wb),
    .select_reg_dbg(select_reg_dbg), .addr_reg_debug(addr_reg_debug), .data_reg_debug(data_reg_debug),
    .select_mem_dbg(select_mem_dbg), .addr_mem_debug(addr_mem_debug), .data_mem_debug(data_mem_debug),
    .pc_debug(pc_debug), .busy(busy)
  );

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return 32'hA5000000 + {27'b0, a} * 32'h00010101;
  endfunction
  function automatic logic [31:0] mem_val(input logic [6:0] a);
    return 32'h3C000000 + {25'b0, a} * 32'h00020301;
  endfunction

  // Register file / data memory with one cycle of read latency.
  always @(posedge clock) begin
    data_reg_debug <= reg_val(addr_reg_debug);
    data_mem_debug <= mem_val(addr_mem_debug);
  end

  always @(posedge clock) begin
    if (tx_valid && tx_ready) rx_q.push_back(tx_data);
    if (inst_write) begin wa_q.push_back(inst_addr); wd_q.push_back(inst_data); end
    if (en_pipeline) en_cnt++;
    if (select_reg_dbg && (!prev_sel || addr_reg_debug != prev_addr)) reg_seq.push_back(addr_reg_debug);
    if (stalled && !reset) begin
      checks++;
      assert (tx_valid === 1'b1 && tx_data === stall_data) else begin
        errors++;
        $error("FAIL tx_hold: observed valid=%0b data=%0h expected valid=1 data=%0h", tx_valid, tx_data, stall_data);
      end
    end
    prev_sel   <= select_reg_dbg;
    prev_addr  <= addr_reg_debug;
    stalled    <= tx_valid && !tx_ready;
    stall_data <= tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1; rx_data = b; rx_valid = 1'b1;
    @(posedge clock); #1; rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) step(1);
    chk(tag, busy, 0);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
  endtask

  task automatic check_dump(input string tag, input logic [31:0] cnt);
    int nbad = 0;
    exp_q.delete();
    push_word(cnt);
    exp_q.push_back(8'h2A);
    for (int i = 0; i < 32; i++) push_word(reg_val(i[4:0]));
    for (int i = 0; i < 32; i++) push_word(mem_val(i[6:0]));
    chk({tag, "_len"}, rx_q.size(), 261);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes_bad"}, nbad, 0);
    chk({tag, "_counter"}, {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nbad;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; halt_wb = 1'b0; pc_debug = 7'h2A;
    // T1 reset values
    step(2);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_en_pipeline", en_pipeline, 0);
    chk("rst_inst_write", inst_write, 0);
    chk("rst_en_read_inst", en_read_inst, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(2);

    // T2 load two words
    wa_q.delete(); wd_q.delete();
    send_byte(8'h01);
    chk("load_busy", busy, 1);
    chk("load_en_read_inst", en_read_inst, 0);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    step(3);
    chk("load_nwrites", wa_q.size(), 2);
    chk("load_addr0", wa_q[0], 0);
    chk("load_data0", wd_q[0], 32'h20010005);
    chk("load_addr1", wa_q[1], 1);
    chk("load_data1", wd_q[1], 32'hFFFFFFFF);
    chk("load_en_read_inst_back", en_read_inst, 1);
    chk("load_idle", busy, 0);

    // T3 run, halt in the 10th enabled cycle
    en_cnt = 0; rx_q.delete();
    send_byte(8'h02);
    for (int i = 0; i < 8 && en_pipeline !== 1'b1; i++) step(1);
    chk("run_en_rise", en_pipeline, 1);
    step(9);
    halt_wb = 1'b1;
    step(1);
    halt_wb = 1'b0;
    chk("run_en_drop", en_pipeline, 0);
    wait_idle("run_idle");
    chk("run_en_cycles", en_cnt, 10);
    check_dump("run", 32'd10);

    // RUN with the halt flag still set dumps at once without enabling the pipeline
    en_cnt = 0; rx_q.delete();
    send_byte(8'h02);
    wait_idle("rerun_idle");
    chk("rerun_en_cycles", en_cnt, 0);
    check_dump("rerun", 32'd10);

    // T4 reload, then two single steps
    wa_q.delete(); wd_q.delete();
    send_byte(8'h01);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    step(3);
    chk("reload_nwrites", wa_q.size(), 1);
    chk("reload_addr0", wa_q[0], 0);
    chk("reload_idle", busy, 0);
    en_cnt = 0; rx_q.delete();
    send_byte(8'h03);
    wait_idle("step1_idle");
    chk("step1_en_cycles", en_cnt, 1);
    check_dump("step1", 32'd1);
    en_cnt = 0; rx_q.delete();
    send_byte(8'h03);
    wait_idle("step2_idle");
    chk("step2_en_cycles", en_cnt, 1);
    check_dump("step2", 32'd2);

    // T5 back-pressure in the register section; a command byte meanwhile is dropped
    rx_q.delete(); reg_seq.delete(); wa_q.delete();
    send_byte(8'h03);
    for (int i = 0; i < 2000 && !(select_reg_dbg === 1'b1 && addr_reg_debug === 5'd10); i++) step(1);
    chk("stall_reached", {select_reg_dbg, addr_reg_debug}, {1'b1, 5'd10});
    tx_ready = 1'b0;
    send_byte(8'h01);
    step(48);
    tx_ready = 1'b1;
    wait_idle("stall_idle");
    check_dump("stall", 32'd3);
    chk("stall_reg_seq_len", reg_seq.size(), 32);
    nbad = 0;
    for (int i = 0; i < reg_seq.size(); i++) if (reg_seq[i] !== i[4:0]) nbad++;
    chk("stall_reg_seq_bad", nbad, 0);
    chk("stall_rx_dropped", wa_q.size(), 0);

    // T6 reset during the memory section, then an unknown command
    send_byte(8'h03);
    for (int i = 0; i < 2000 && select_mem_dbg !== 1'b1; i++) step(1);
    chk("abort_in_mem", select_mem_dbg, 1);
    reset = 1'b1;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_sel_mem", select_mem_dbg, 0);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_en_read_inst", en_read_inst, 1);
    reset = 1'b0;
    send_byte(8'h7E);
    chk("ignore_busy_a", busy, 0);
    step(5);
    chk("ignore_busy_b", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
